// File: rtl/ascon_core_arbiter.sv
// Routes one of N_CH protocol sub-FSMs onto the shared Ascon core and output stream, with a 2-entry output skid.
// Optional: ASCON_ARB_PERF_CNT_EN adds per-operation busy-cycle and output-beat counters.
module ascon_core_arbiter #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 64,
    parameter int USER_W = 3,
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int KEEP_W = DATA_W / 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [CH_W-1:0]          mode_i,
    input  logic                     start_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     tag_fail_o,
    output logic                     err_o,
    output logic [1:0]               dbg_state_o,
    output logic [N_CH-1:0]          ch_start_o,
    input  logic [N_CH-1:0]          ch_done_i,
    input  logic [N_CH-1:0]          ch_tag_fail_i,
    input  logic [N_CH-1:0]          ch_start_perm_i,
    input  logic [N_CH-1:0]          ch_round_config_i,
    input  logic [N_CH-1:0]          ch_write_en_i,
    input  logic [3*N_CH-1:0]        ch_word_sel_i,
    input  logic [2*N_CH-1:0]        ch_data_sel_i,
    input  logic [DATA_W*N_CH-1:0]   ch_data_i,
    output logic                     core_start_perm_o,
    output logic                     core_round_config_o,
    output logic                     core_write_en_o,
    output logic [2:0]               core_word_sel_o,
    output logic [DATA_W-1:0]        core_data_o,
    input  logic [DATA_W-1:0]        core_state_i,
    input  logic                     core_ready_i,
    input  logic [DATA_W-1:0]        s_axis_tdata,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic [N_CH-1:0]          ch_s_tready_i,
    output logic [N_CH-1:0]          ch_s_tvalid_o,
    input  logic [DATA_W*N_CH-1:0]   ch_m_tdata_i,
    input  logic [KEEP_W*N_CH-1:0]   ch_m_tkeep_i,
    input  logic [USER_W*N_CH-1:0]   ch_m_tuser_i,
    input  logic [N_CH-1:0]          ch_m_tlast_i,
    input  logic [N_CH-1:0]          ch_m_tvalid_i,
    output logic [N_CH-1:0]          ch_m_tready_o,
    output logic [DATA_W-1:0]        m_axis_tdata,
    output logic [KEEP_W-1:0]        m_axis_tkeep,
    output logic [USER_W-1:0]        m_axis_tuser,
    output logic                     m_axis_tlast,
    output logic                     m_axis_tvalid,
`ifdef ASCON_ARB_PERF_CNT_EN
    output logic [31:0]              perf_cycles_o,
    output logic [31:0]              perf_beats_o,
`endif
    input  logic                     m_axis_tready
);
    // Handshakes: a beat transfers on a rising clk edge where valid and ready are both high;
    // valid never waits on ready, and a held beat keeps its payload stable until taken.

    localparam int BW = 1 + USER_W + KEEP_W + DATA_W;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DRAIN  = 2'd2
    } state_t;

    state_t            state_q;
    logic [CH_W-1:0]   sel_q;
    logic              busy_q, done_q, err_q, tag_fail_q;
    logic [N_CH-1:0]   ch_start_q;
    logic [1:0]        cnt_q;
    logic [BW-1:0]     ent0_q, ent1_q;

    logic [DATA_W-1:0] data_a     [N_CH];
    logic [2:0]        word_sel_a [N_CH];
    logic [1:0]        data_sel_a [N_CH];
    logic [BW-1:0]     beat_a     [N_CH];

    logic mode_ok, start_ok, active, skid_full, push, pop;

    for (genvar g = 0; g < N_CH; g++) begin : g_unpack
        assign data_a[g]     = ch_data_i[g*DATA_W +: DATA_W];
        assign word_sel_a[g] = ch_word_sel_i[g*3 +: 3];
        assign data_sel_a[g] = ch_data_sel_i[g*2 +: 2];
        assign beat_a[g]     = {ch_m_tlast_i[g], ch_m_tuser_i[g*USER_W +: USER_W],
                                ch_m_tkeep_i[g*KEEP_W +: KEEP_W], ch_m_tdata_i[g*DATA_W +: DATA_W]};
    end

    if (N_CH == (1 << CH_W)) begin : g_pow2
        assign mode_ok = 1'b1;
    end else begin : g_npow2
        assign mode_ok = (int'(mode_i) < N_CH);
    end

    assign start_ok  = mode_ok & core_ready_i;
    assign active    = (state_q == S_ACTIVE);
    assign skid_full = (cnt_q == 2'd2);
    assign push      = active & ch_m_tvalid_i[sel_q] & ~skid_full;
    assign pop       = m_axis_tvalid & m_axis_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            sel_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            tag_fail_q <= 1'b0;
            ch_start_q <= '0;
        end else begin
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            ch_start_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (start_i && start_ok) begin
                        sel_q      <= mode_i;
                        tag_fail_q <= 1'b0;
                        ch_start_q <= N_CH'(1) << mode_i;
                        busy_q     <= 1'b1;
                        state_q    <= S_ACTIVE;
                    end else if (start_i) begin
                        err_q <= 1'b1;
                    end
                end
                S_ACTIVE: begin
                    if (start_i) err_q <= 1'b1;
                    if (ch_done_i[sel_q]) begin
                        tag_fail_q <= tag_fail_q | ch_tag_fail_i[sel_q];
                        state_q    <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (start_i) err_q <= 1'b1;
                    // Completion waits until every produced beat has left the skid.
                    if (cnt_q == 2'd0) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        core_start_perm_o   = 1'b0;
        core_round_config_o = 1'b0;
        core_write_en_o     = 1'b0;
        core_word_sel_o     = 3'd0;
        core_data_o         = '0;
        s_axis_tready       = 1'b0;
        ch_s_tvalid_o       = '0;
        ch_m_tready_o       = '0;
        if (active) begin
            core_start_perm_o   = ch_start_perm_i[sel_q];
            core_round_config_o = ch_round_config_i[sel_q];
            core_write_en_o     = ch_write_en_i[sel_q];
            core_word_sel_o     = word_sel_a[sel_q];
            case (data_sel_a[sel_q])
                2'b00:   core_data_o = s_axis_tdata;
                2'b01:   core_data_o = data_a[sel_q];
                2'b10:   core_data_o = core_state_i ^ s_axis_tdata;
                default: core_data_o = '0;
            endcase
            s_axis_tready        = ch_s_tready_i[sel_q];
            ch_s_tvalid_o[sel_q] = s_axis_tvalid;
            ch_m_tready_o[sel_q] = ~skid_full;
        end
    end

    // Entry 0 is always the head; push and pop together only happen at count 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 2'd0;
            ent0_q <= '0;
            ent1_q <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) ent0_q <= beat_a[sel_q];
                    else               ent1_q <= beat_a[sel_q];
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    ent0_q <= ent1_q;
                    cnt_q  <= cnt_q - 2'd1;
                end
                2'b11:   ent0_q <= beat_a[sel_q];
                default: ;
            endcase
        end
    end

`ifdef ASCON_ARB_PERF_CNT_EN
    logic [31:0] perf_cycles_q, perf_beats_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles_q <= '0;
            perf_beats_q  <= '0;
        end else if (state_q == S_IDLE && start_i && start_ok) begin
            perf_cycles_q <= '0;
            perf_beats_q  <= '0;
        end else begin
            if (busy_q && perf_cycles_q != '1)       perf_cycles_q <= perf_cycles_q + 32'd1;
            if (busy_q && pop && perf_beats_q != '1) perf_beats_q  <= perf_beats_q + 32'd1;
        end
    end

    assign perf_cycles_o = perf_cycles_q;
    assign perf_beats_o  = perf_beats_q;
`endif

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign tag_fail_o    = tag_fail_q;
    assign ch_start_o    = ch_start_q;
    assign dbg_state_o   = state_q;
    assign m_axis_tvalid = (cnt_q != 2'd0);
    assign {m_axis_tlast, m_axis_tuser, m_axis_tkeep, m_axis_tdata} = ent0_q;

endmodule

// File: tb/tb_ascon_core_arbiter.sv
// Bench for ascon_core_arbiter: directed control checks plus a scoreboard on the output stream.
module tb_ascon_core_arbiter;
    localparam int N_CH = 4, DATA_W = 64, USER_W = 3, KEEP_W = 8;
    localparam int BW = 1 + USER_W + KEEP_W + DATA_W;

    logic clk, rst_n;
    logic [1:0] mode_i;
    logic start_i, busy_o, done_o, tag_fail_o, err_o;
    logic [1:0] dbg_state_o;
    logic [N_CH-1:0] ch_start_o, ch_done_i, ch_tag_fail_i;
    logic [N_CH-1:0] ch_start_perm_i, ch_round_config_i, ch_write_en_i;
    logic [3*N_CH-1:0] ch_word_sel_i;
    logic [2*N_CH-1:0] ch_data_sel_i;
    logic [DATA_W*N_CH-1:0] ch_data_i;
    logic core_start_perm_o, core_round_config_o, core_write_en_o;
    logic [2:0] core_word_sel_o;
    logic [DATA_W-1:0] core_data_o, core_state_i;
    logic core_ready_i;
    logic [DATA_W-1:0] s_axis_tdata;
    logic s_axis_tvalid, s_axis_tready;
    logic [N_CH-1:0] ch_s_tready_i, ch_s_tvalid_o;
    logic [DATA_W*N_CH-1:0] ch_m_tdata_i;
    logic [KEEP_W*N_CH-1:0] ch_m_tkeep_i;
    logic [USER_W*N_CH-1:0] ch_m_tuser_i;
    logic [N_CH-1:0] ch_m_tlast_i, ch_m_tvalid_i, ch_m_tready_o;
    logic [DATA_W-1:0] m_axis_tdata;
    logic [KEEP_W-1:0] m_axis_tkeep;
    logic [USER_W-1:0] m_axis_tuser;
    logic m_axis_tlast, m_axis_tvalid, m_axis_tready;
`ifdef ASCON_ARB_PERF_CNT_EN
    logic [31:0] perf_cycles_o, perf_beats_o;
    int busy_cnt = 0;
    always @(negedge clk) if (busy_o) busy_cnt++;
`endif

    ascon_core_arbiter #(.N_CH(N_CH), .DATA_W(DATA_W), .USER_W(USER_W)) dut (
        .clk(clk), .rst_n(rst_n), .mode_i(mode_i), .start_i(start_i),
        .busy_o(busy_o), .done_o(done_o), .tag_fail_o(tag_fail_o), .err_o(err_o),
        .dbg_state_o(dbg_state_o), .ch_start_o(ch_start_o), .ch_done_i(ch_done_i),
        .ch_tag_fail_i(ch_tag_fail_i), .ch_start_perm_i(ch_start_perm_i),
        .ch_round_config_i(ch_round_config_i), .ch_write_en_i(ch_write_en_i),
        .ch_word_sel_i(ch_word_sel_i), .ch_data_sel_i(ch_data_sel_i), .ch_data_i(ch_data_i),
        .core_start_perm_o(core_start_perm_o), .core_round_config_o(core_round_config_o),
        .core_write_en_o(core_write_en_o), .core_word_sel_o(core_word_sel_o),
        .core_data_o(core_data_o), .core_state_i(core_state_i), .core_ready_i(core_ready_i),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .ch_s_tready_i(ch_s_tready_i), .ch_s_tvalid_o(ch_s_tvalid_o),
        .ch_m_tdata_i(ch_m_tdata_i), .ch_m_tkeep_i(ch_m_tkeep_i), .ch_m_tuser_i(ch_m_tuser_i),
        .ch_m_tlast_i(ch_m_tlast_i), .ch_m_tvalid_i(ch_m_tvalid_i), .ch_m_tready_o(ch_m_tready_o),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
        .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid),
`ifdef ASCON_ARB_PERF_CNT_EN
        .perf_cycles_o(perf_cycles_o), .perf_beats_o(perf_beats_o),
`endif
        .m_axis_tready(m_axis_tready)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;
    logic [BW-1:0] exp_q[$];
    bit rand_rdy = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BW-1:0] rand_beat();
        return {1'($urandom_range(0, 1)), 3'($urandom), 8'($urandom), 32'($urandom), 32'($urandom)};
    endfunction

    task automatic set_beat(input int ch, input logic [BW-1:0] b);
        ch_m_tdata_i[ch*DATA_W +: DATA_W] = b[DATA_W-1:0];
        ch_m_tkeep_i[ch*KEEP_W +: KEEP_W] = b[DATA_W +: KEEP_W];
        ch_m_tuser_i[ch*USER_W +: USER_W] = b[DATA_W+KEEP_W +: USER_W];
        ch_m_tlast_i[ch]                  = b[BW-1];
    endtask

    // Driver: offer one beat on channel ch; expectation queued on the accepting edge.
    task automatic send_beat(input int ch, input logic [BW-1:0] b);
        bit ok = 0;
        set_beat(ch, b);
        ch_m_tvalid_i[ch] = 1'b1;
        for (int k = 0; k < 40 && !ok; k++) begin
            if (rand_rdy) m_axis_tready = ($urandom_range(0, 3) != 0);
            #0;
            if (ch_m_tready_o[ch]) begin
                exp_q.push_back(b);
                ok = 1;
            end
            tick();
        end
        ch_m_tvalid_i[ch] = 1'b0;
        chk("send_accept", ok, 1);
    endtask

    task automatic start_op(input int ch);
        mode_i  = 2'(ch);
        start_i = 1'b1;
`ifdef ASCON_ARB_PERF_CNT_EN
        busy_cnt = 0;
`endif
        tick();
        start_i = 1'b0;
        chk("start_onehot", ch_start_o, 4'b0001 << ch);
        chk("start_busy", busy_o, 1);
        chk("start_err", err_o, 0);
    endtask

    task automatic ch_finish(input int ch, input logic tf);
        ch_done_i[ch]     = 1'b1;
        ch_tag_fail_i[ch] = tf;
        tick();
        ch_done_i[ch]     = 1'b0;
        ch_tag_fail_i[ch] = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int k = 0; k < 60 && !seen; k++) begin
            if (done_o) seen = 1;
            else tick();
        end
        chk("done_seen", seen, 1);
        chk("done_busy_low", busy_o, 0);
        tick();
        chk("done_pulse_one_cycle", done_o, 0);
    endtask

    // Scoreboard: every output handshake must match the oldest accepted channel beat.
    always @(negedge clk) begin
        if (rst_n && m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) chk("skid_unexpected_beat", 1, 0);
            else chk("skid_beat", {m_axis_tlast, m_axis_tuser, m_axis_tkeep, m_axis_tdata}, exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BW-1:0] b [4];
        int idx;

        rst_n = 0; mode_i = 0; start_i = 0;
        ch_done_i = 0; ch_tag_fail_i = 0; ch_start_perm_i = 0; ch_round_config_i = 0;
        ch_write_en_i = 0; ch_word_sel_i = 0; ch_data_sel_i = 0; ch_data_i = 0;
        core_state_i = 0; core_ready_i = 1; s_axis_tdata = 0; s_axis_tvalid = 0;
        ch_s_tready_i = 0; ch_m_tdata_i = 0; ch_m_tkeep_i = 0; ch_m_tuser_i = 0;
        ch_m_tlast_i = 0; ch_m_tvalid_i = 0; m_axis_tready = 1;
        repeat (3) tick();
        chk("rst_busy", busy_o, 0);
        chk("rst_state", dbg_state_o, 0);
        chk("rst_mvalid", m_axis_tvalid, 0);
        chk("rst_ch_start", ch_start_o, 0);
        rst_n = 1;
        tick();

        // Channel 1 owns the core; foreign strobes are ignored.
        start_op(1);
        tick();
        chk("ch_start_pulse", ch_start_o, 0);
        ch_start_perm_i = 4'b1101; ch_round_config_i = 4'b0010; ch_write_en_i = 4'b1101;
        ch_word_sel_i = {3'd7, 3'd2, 3'd5, 3'd1};
        ch_data_sel_i = {2'b10, 2'b11, 2'b01, 2'b00};
        ch_data_i[DATA_W +: DATA_W] = 64'hA5A5_0F0F_1234_CAFE;
        ch_s_tready_i = 4'b0010; s_axis_tvalid = 1'b1;
        #1;
        chk("ch1_perm", core_start_perm_o, 0);
        chk("ch1_rc", core_round_config_o, 1);
        chk("ch1_we", core_write_en_o, 0);
        chk("ch1_word", core_word_sel_o, 5);
        chk("ch1_data", core_data_o, 64'hA5A5_0F0F_1234_CAFE);
        chk("ch1_s_tready", s_axis_tready, 1);
        chk("ch1_s_tvalid", ch_s_tvalid_o, 4'b0010);
        chk("ch1_m_tready_mask", ch_m_tready_o, 4'b0010);
        ch_start_perm_i = 0; ch_round_config_i = 0; ch_write_en_i = 0; ch_data_sel_i = 0;
        ch_s_tready_i = 0; s_axis_tvalid = 0;
        ch_done_i = 4'b1001;
        tick();
        ch_done_i = 0;
        chk("foreign_done_ignored", dbg_state_o, 1);
        mode_i = 1; start_i = 1;
        tick();
        start_i = 0;
        chk("busy_start_err", err_o, 1);
        chk("busy_start_no_ch_start", ch_start_o, 0);
        chk("busy_start_state", dbg_state_o, 1);
        tick();
        chk("busy_err_one_cycle", err_o, 0);
        set_beat(3, rand_beat());
        ch_m_tvalid_i[3] = 1'b1;
        rand_rdy = 1;
        for (int i = 0; i < 12; i++) send_beat(1, rand_beat());
        rand_rdy = 0; m_axis_tready = 1; ch_m_tvalid_i[3] = 1'b0;
        ch_finish(1, 1'b0);
        wait_done();
        chk("ch1_tag_ok", tag_fail_o, 0);

        // Rejected start: core not ready.
        core_ready_i = 0; mode_i = 2; start_i = 1;
        tick();
        start_i = 0; core_ready_i = 1;
        chk("rej_err", err_o, 1);
        chk("rej_no_start", ch_start_o, 0);
        chk("rej_state", dbg_state_o, 0);
        tick();
        chk("rej_err_one_cycle", err_o, 0);

        // AEAD decrypt path and data-select variants, then MAC fail with a pending beat.
        start_op(0);
        core_state_i = 64'hFFFF_0000_FFFF_0000; s_axis_tdata = 64'h1234_5678_9ABC_DEF0;
        ch_data_sel_i[1:0] = 2'b10; #1;
        chk("xor_path", core_data_o, 64'hEDCB_5678_6543_DEF0);
        ch_data_sel_i[1:0] = 2'b00; #1;
        chk("axis_path", core_data_o, 64'h1234_5678_9ABC_DEF0);
        ch_data_sel_i[1:0] = 2'b11; #1;
        chk("zero_path", core_data_o, 0);
        ch_data_sel_i[1:0] = 2'b10; ch_round_config_i[0] = 1'b1;
        m_axis_tready = 0;
        send_beat(0, rand_beat());
        ch_finish(0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("drain_hold_done", done_o, 0);
            chk("drain_state", dbg_state_o, 2);
            chk("drain_core_rc", core_round_config_o, 0);
            chk("drain_core_data", core_data_o, 0);
            tick();
        end
        m_axis_tready = 1; ch_round_config_i = 0; ch_data_sel_i = 0;
        wait_done();
        chk("tag_fail_set", tag_fail_o, 1);
        tick(); tick();
        chk("tag_fail_held", tag_fail_o, 1);

        // Channel 2 streams into a stalled output.
        m_axis_tready = 0;
        start_op(2);
        chk("tag_fail_cleared", tag_fail_o, 0);
        for (int i = 0; i < 4; i++) b[i] = rand_beat();
        idx = 0;
        ch_m_tvalid_i[2] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            set_beat(2, b[idx]);
            #0;
            if (ch_m_tready_o[2]) begin exp_q.push_back(b[idx]); idx++; end
            tick();
        end
        chk("bp_accepted", idx, 2);
        chk("bp_ready_low", ch_m_tready_o[2], 0);
        chk("bp_head_data", m_axis_tdata, b[0][DATA_W-1:0]);
        tick();
        chk("bp_head_stable", m_axis_tdata, b[0][DATA_W-1:0]);
        m_axis_tready = 1;
        for (int c = 0; c < 20 && idx < 4; c++) begin
            set_beat(2, b[idx]);
            #0;
            if (ch_m_tready_o[2]) begin exp_q.push_back(b[idx]); idx++; end
            tick();
        end
        ch_m_tvalid_i[2] = 1'b0;
        chk("bp_all_accepted", idx, 4);
        ch_finish(2, 1'b0);
        wait_done();
        chk("bp_queue_empty", exp_q.size(), 0);
`ifdef ASCON_ARB_PERF_CNT_EN
        chk("perf_beats", perf_beats_o, 4);
        chk("perf_cycles", perf_cycles_o, busy_cnt);
`endif

        // Asynchronous reset with a beat held in the skid.
        m_axis_tready = 0;
        start_op(3);
        send_beat(3, rand_beat());
        chk("pre_rst_mvalid", m_axis_tvalid, 1);
        rst_n = 0;
        #1;
        exp_q.delete();
        chk("arst_busy", busy_o, 0);
        chk("arst_mvalid", m_axis_tvalid, 0);
        chk("arst_state", dbg_state_o, 0);
        chk("arst_m_tready", ch_m_tready_o, 0);
        chk("arst_core_data", core_data_o, 0);
        chk("arst_mdata", m_axis_tdata, 0);
        tick();
        rst_n = 1; m_axis_tready = 1;
        tick();
        start_op(3);
        ch_finish(3, 1'b0);
        wait_done();
        chk("end_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
